// File: rtl/l1_cache_pkg.sv
// Shared types and encodings for the 2-way L1 cache controller.
package l1_cache_pkg;

  localparam int unsigned AW_W = 4;

  // Bit positions inside a way's array_write strobe vector
  localparam int unsigned AW_DATA  = 0;
  localparam int unsigned AW_TAG   = 1;
  localparam int unsigned AW_VALID = 2;
  localparam int unsigned AW_DIRTY = 3;

  // Strobe patterns: CPU write hit touches data+dirty, a fill touches everything
  localparam logic [AW_W-1:0] AW_NONE      = '0;
  localparam logic [AW_W-1:0] AW_WRITE_HIT = (AW_W'(1) << AW_DATA) | (AW_W'(1) << AW_DIRTY);
  localparam logic [AW_W-1:0] AW_FILL      = (AW_W'(1) << AW_DATA)  | (AW_W'(1) << AW_TAG) |
                                             (AW_W'(1) << AW_VALID) | (AW_W'(1) << AW_DIRTY);

  // data_sel / pmem_addr_sel encodings
  localparam logic DATA_SEL_CPU    = 1'b0;
  localparam logic DATA_SEL_PMEM   = 1'b1;
  localparam logic ADDR_SEL_CPU    = 1'b0;
  localparam logic ADDR_SEL_VICTIM = 1'b1;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

endpackage

// File: rtl/l1_lru_array.sv
// Per-set 1-bit LRU store: combinational read, synchronous write, async clear.
module l1_lru_array #(
  parameter int unsigned SETS    = 8,
  parameter int unsigned INDEX_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] index,
  input  logic               we,
  input  logic               wdata,
  output logic               rdata
);

  logic [SETS-1:0] lru_q;

  assign rdata = lru_q[index];

  // LRU bit update at the addressed set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else if (we) begin
      lru_q[index] <= wdata;
    end
  end

endmodule

// File: rtl/l1_cache_control.sv
// Control FSM for the 2-way, 8-set L1 cache: hit/miss decision, victim
// writeback, line allocate and per-set LRU ownership.
// Optional macro L1_CTRL_PERF_EN adds saturating hit_count/miss_count outputs.
module l1_cache_control
  import l1_cache_pkg::*;
#(
  parameter int unsigned SETS    = 8,
  parameter int unsigned INDEX_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] index,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               mem_resp,
  input  logic [1:0]         hit,
  input  logic [1:0]         valid,
  input  logic [1:0]         dirty,
  output logic               pmem_read,
  output logic               pmem_write,
  input  logic               pmem_resp,
  output logic [3:0]         way0_array_write,
  output logic [3:0]         way1_array_write,
  output logic               dirty_in,
  output logic               data_sel,
  output logic               pmem_addr_sel
`ifdef L1_CTRL_PERF_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  state_e state_q, state_d;
  logic   victim_q, victim_d;
  logic   lru_rd, lru_we, lru_wd;
  logic   req, hit_any, hit_way, miss_victim, victim_dirty;
  logic   miss_ev;
  logic [1:0][AW_W-1:0] aw;

  assign req          = mem_read | mem_write;
  assign hit_any      = |hit;
  // Illegal double hit resolves to way 0
  assign hit_way      = hit[0] ? 1'b0 : 1'b1;
  // Prefer an invalid way, otherwise evict the least recently used one
  assign miss_victim  = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru_rd);
  assign victim_dirty = valid[miss_victim] & dirty[miss_victim];
  assign miss_ev      = rst_n && (state_q == CHECK) && req && !hit_any;

  assign way0_array_write = aw[0];
  assign way1_array_write = aw[1];

  l1_lru_array #(
    .SETS    (SETS),
    .INDEX_W (INDEX_W)
  ) u_lru (
    .clk   (clk),
    .rst_n (rst_n),
    .index (index),
    .we    (lru_we),
    .wdata (lru_wd),
    .rdata (lru_rd)
  );

  // State and victim registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CHECK;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Next-state and output decode; everything forced low while in reset
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    lru_we        = 1'b0;
    lru_wd        = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    aw            = '0;
    dirty_in      = 1'b0;
    data_sel      = DATA_SEL_CPU;
    pmem_addr_sel = ADDR_SEL_CPU;
    if (rst_n) begin
      case (state_q)
        CHECK: begin
          if (req) begin
            if (hit_any) begin
              mem_resp = 1'b1;
              lru_we   = 1'b1;
              lru_wd   = ~hit_way;
              if (mem_write) begin
                aw[hit_way] = AW_WRITE_HIT;
                dirty_in    = 1'b1;
                data_sel    = DATA_SEL_CPU;
              end
            end else begin
              victim_d = miss_victim;
              state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = ADDR_SEL_VICTIM;
          if (pmem_resp) begin
            state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read     = 1'b1;
          pmem_addr_sel = ADDR_SEL_CPU;
          if (pmem_resp) begin
            aw[victim_q] = AW_FILL;
            dirty_in     = 1'b0;
            data_sel     = DATA_SEL_PMEM;
            state_d      = CHECK;
          end
        end
        default: begin
          state_d = CHECK;
        end
      endcase
    end
  end

`ifdef L1_CTRL_PERF_EN
  // Saturating hit/miss event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (mem_resp && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_ev && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
